// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one synchronous-read data memory between two requesters (m0, m1).
// Each transaction takes exactly four cycles: IDLE (arbitrate and latch),
// ISSUE (drive the memory request), WAIT (capture the read data) and
// DONE (one-cycle ready pulse to the owner).
//
// When both requesters ask at once, the grant goes to the one that did not
// win last time. Misaligned or out-of-range accesses never reach the memory.
// They still complete, with err_o set and, for reads, rdata_o cleared.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   m<k>_req_i                request from requester k, held until ready
//   m<k>_we_i                 1 = write, 0 = read
//   m<k>_addr_i, m<k>_wdata_i byte address and write data
//   m<k>_ready_o, m<k>_err_o  completion pulse and rejected-access flag
//   m<k>_rdata_o              last completed read data for requester k
//   mem_req_o, mem_we_o       memory request and write enable
//   mem_addr_o, mem_wdata_o   memory byte address and write data
//   mem_rdata_i               memory read data, one cycle after request
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ready_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ready_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // The limit is one bit wider than the address so that the range check
  // compares the full 32-bit address even if MEM_BYTES were 2**32.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state_q, state_d;
  logic        owner_q;
  logic        last_owner_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] m0_rdata_q;
  logic [31:0] m1_rdata_q;

  logic        any_req;
  logic        grant_m1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic [31:0] rdata_next;

  // m1 wins when it is the only requester, or on a tie when m0 won last.
  assign any_req   = m0_req_i | m1_req_i;
  assign grant_m1  = m1_req_i & (~m0_req_i | ~last_owner_q);
  assign sel_we    = grant_m1 ? m1_we_i    : m0_we_i;
  assign sel_addr  = grant_m1 ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = grant_m1 ? m1_wdata_i : m0_wdata_i;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= MEM_LIMIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // After IDLE, the FSM moves through one state per cycle.
  // Request inputs are only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    m0_ready_o  = 1'b0;
    m1_ready_o  = 1'b0;
    m0_err_o    = 1'b0;
    m1_err_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_o = ~err_q;
        mem_we_o  = ~err_q & we_q;
        state_d   = WAIT;
      end
      WAIT: begin
        state_d = DONE;
      end
      DONE: begin
        m0_ready_o = ~owner_q;
        m1_ready_o = owner_q;
        m0_err_o   = ~owner_q & err_q;
        m1_err_o   = owner_q & err_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The request is captured in IDLE, and the captured copy is used for the
  // rest of the transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
    end else if (state_q == IDLE && any_req) begin
      owner_q      <= grant_m1;
      last_owner_q <= grant_m1;
      we_q         <= sel_we;
      err_q        <= sel_err;
      addr_q       <= sel_addr;
      wdata_q      <= sel_wdata;
    end
  end

  // A rejected read returns zero rather than stale memory data.
  assign rdata_next = err_q ? 32'h0 : mem_rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
    end else if (state_q == WAIT && !we_q) begin
      if (owner_q) begin
        m1_rdata_q <= rdata_next;
      end else begin
        m0_rdata_q <= rdata_next;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Directed bench for data_mem_arbiter. Expected completions are queued as
// stimulus is issued. A negedge monitor pops one entry per ready pulse and
// checks the owner, err and rdata. Memory words that have never been written
// read back as 0xA5000000 | word_index.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_addr_i = 32'h0, m0_wdata_i = 32'h0;
  logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_addr_i = 32'h0, m1_wdata_i = 32'h0;
  logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;

  logic [31:0] mem_words [4096];
  bit          mem_written [4096];

  exp_t sb_q[$];
  int   assert_count = 0;
  int   fail_count = 0;

  data_mem_arbiter #(.MEM_BYTES(16384)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o),
    .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read memory model.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        mem_words[mem_addr_o[13:2]]   <= mem_wdata_o;
        mem_written[mem_addr_o[13:2]] <= 1'b1;
      end
      mem_rdata_i <= mem_written[mem_addr_o[13:2]] ? mem_words[mem_addr_o[13:2]]
                                                   : {20'hA5000, mem_addr_o[13:2]};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (!m0_ready_o) checkOutput("m0_err_without_ready", {31'h0, m0_err_o}, 32'h0);
    if (!m1_ready_o) checkOutput("m1_err_without_ready", {31'h0, m1_err_o}, 32'h0);
    if (mem_req_o) begin
      checkOutput("mem_addr_legal",
                  {31'h0, (mem_addr_o < 32'h4000) && (mem_addr_o[1:0] == 2'b00)}, 32'h1);
    end
    if (m0_ready_o || m1_ready_o) begin
      checkOutput("single_ready", {31'h0, m0_ready_o & m1_ready_o}, 32'h0);
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_ready", {30'h0, m1_ready_o, m0_ready_o}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("ready_owner", {31'h0, m1_ready_o}, {31'h0, e.port});
        checkOutput("ready_err", {31'h0, e.port ? m1_err_o : m0_err_o}, {31'h0, e.err});
        checkOutput("ready_rdata", e.port ? m1_rdata_o : m0_rdata_o, e.rdata);
      end
    end
  end

  task automatic drivePort(input bit port, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wdata;
    end else begin
      m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata;
    end
  endtask

  // One single-requester transaction, started just after a rising edge while
  // the DUT is idle. exp_rdata is the owner's rdata_o expected during DONE.
  task automatic applyStimulus(input bit port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic exp_err,
                               input logic [31:0] exp_rdata, input bit drop_early);
    sb_q.push_back('{port: port, err: exp_err, rdata: exp_rdata});
    drivePort(port, 1'b1, we, addr, wdata);
    @(posedge clk_i);
    if (drop_early) begin
      #1 drivePort(port, 1'b0, we, addr, wdata);
    end
    @(negedge clk_i);
    checkOutput("issue_mem_req", {31'h0, mem_req_o}, {31'h0, ~exp_err});
    checkOutput("issue_mem_we", {31'h0, mem_we_o}, {31'h0, we & ~exp_err});
    checkOutput("issue_mem_addr", mem_addr_o, addr);
    if (we) checkOutput("issue_mem_wdata", mem_wdata_o, wdata);
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("wait_mem_req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("wait_no_ready", {30'h0, m1_ready_o, m0_ready_o}, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("done_ready_latency", {31'h0, port ? m1_ready_o : m0_ready_o}, 32'h1);
    @(posedge clk_i);
    #1 drivePort(port, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int ready_cycle [4];
    int n_ready;
    int cyc;

    $display("[TB] reset phase");
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_ready", {30'h0, m1_ready_o, m0_ready_o}, 32'h0);
    checkOutput("rst_mem_req_we", {30'h0, mem_req_o, mem_we_o}, 32'h0);
    checkOutput("rst_m0_rdata", m0_rdata_o, 32'h0);
    checkOutput("rst_m1_rdata", m1_rdata_o, 32'h0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Both requesters hold reads from reset: grants alternate m0, m1, m0, m1.
    $display("[TB] alternating grants");
    sb_q.push_back('{port: 1'b0, err: 1'b0, rdata: 32'hA5000008});
    sb_q.push_back('{port: 1'b1, err: 1'b0, rdata: 32'hA5000009});
    sb_q.push_back('{port: 1'b0, err: 1'b0, rdata: 32'hA5000008});
    sb_q.push_back('{port: 1'b1, err: 1'b0, rdata: 32'hA5000009});
    drivePort(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    drivePort(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    n_ready = 0;
    cyc = 0;
    while (n_ready < 4 && cyc < 40) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      if (m0_ready_o || m1_ready_o) begin
        ready_cycle[n_ready] = cyc;
        n_ready++;
      end
    end
    checkOutput("alt_ready_count", n_ready, 4);
    checkOutput("alt_first_latency", ready_cycle[0], 3);
    for (int i = 1; i < 4; i++) begin
      if (i < n_ready) checkOutput("alt_spacing", ready_cycle[i] - ready_cycle[i-1], 4);
    end
    @(posedge clk_i);
    #1;
    drivePort(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drivePort(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] write then read back");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'hA5000008, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 32'hA5000009, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);

    $display("[TB] rejected reads");
    applyStimulus(1'b1, 1'b0, 32'h00004000, 32'h0, 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h00000006, 32'h0, 1'b1, 32'h0, 1'b0);

    $display("[TB] address boundaries");
    applyStimulus(1'b0, 1'b1, 32'h3FFC, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h3FFC, 32'h0, 1'b0, 32'h12345678, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h12345678, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h3FFC, 32'h0, 1'b0, 32'h12345678, 1'b0);

    $display("[TB] request dropped during issue");
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);

    // Reset lands in WAIT of an m1 read. No completion is queued, so any
    // ready pulse is reported by the monitor.
    $display("[TB] reset during wait");
    drivePort(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    drivePort(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("abort_ready", {30'h0, m1_ready_o, m0_ready_o}, 32'h0);
    checkOutput("abort_mem_req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("abort_m0_rdata", m0_rdata_o, 32'h0);
    checkOutput("abort_m1_rdata", m1_rdata_o, 32'h0);
    checkOutput("abort_mem_addr", mem_addr_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'hA5000009, 1'b0);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
